// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression controller:
// FSM state encoding, round index type, default round count and K table.
package sha256_pkg;

  localparam int ROUNDS_DEFAULT = 64;

  typedef logic [5:0] round_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } ctrl_state_e;

  // First 32 bits of the fractional parts of the cube roots of the first 64 primes.
  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/compress_ctrl_if.sv
// Control bundle between the compression controller (slave side) and the
// unit that requests blocks and supplies message words (master side).
interface compress_ctrl_if;
  import sha256_pkg::*;

  logic        start;
  logic        msg_valid;
  logic        ready;
  logic        soc;
  logic        eoc;
  logic        round_en;
  logic        msg_adv;
  round_t      round;
  logic [31:0] k;
  logic        busy;
  logic        done;

  modport master (
    output start, msg_valid,
    input  ready, soc, eoc, round_en, msg_adv, round, k, busy, done
  );

  modport slave (
    input  start, msg_valid,
    output ready, soc, eoc, round_en, msg_adv, round, k, busy, done
  );

endinterface

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup: 6-bit round index to 32-bit K.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  round_t      idx_i,
  output logic [31:0] k_o
);

  assign k_o = K_TABLE[idx_i];

endmodule

// File: rtl/compress_ctrl.sv
// SHA-256 compression round controller. Define CTRL_MSG_STALL_EN to let
// msg_valid stall rounds; otherwise one round executes every ROUND cycle.
module compress_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  compress_ctrl_if.slave bus
);

  localparam round_t LAST_ROUND = round_t'(ROUNDS - 1);

  ctrl_state_e state_q;
  round_t      round_q;
  logic        soc_q;
  logic        eoc_q;
  logic        done_q;
  logic        busy_q;
  logic        ready_q;
  logic        round_en;

`ifdef CTRL_MSG_STALL_EN
  assign round_en = (state_q == ST_ROUND) && bus.msg_valid;
`else
  assign round_en = (state_q == ST_ROUND);
`endif

  // Pulses default low each cycle; branches below raise them for one cycle.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      soc_q   <= 1'b0;
      eoc_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      soc_q  <= 1'b0;
      eoc_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_INIT;
            soc_q   <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_INIT: begin
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          if (round_en) begin
            if (round_q == LAST_ROUND) begin
              state_q <= ST_FINAL;
              round_q <= '0;
              eoc_q   <= 1'b1;
            end else begin
              round_q <= round_q + round_t'(1);
            end
          end
        end
        ST_FINAL: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        ST_DONE: begin
          // A start still high here chains straight into the next block.
          if (bus.start) begin
            state_q <= ST_INIT;
            soc_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          round_q <= '0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  sha256_k_rom u_k_rom (
    .idx_i (round_q),
    .k_o   (bus.k)
  );

  assign bus.ready    = ready_q;
  assign bus.soc      = soc_q;
  assign bus.eoc      = eoc_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.round    = round_q;
  assign bus.round_en = round_en;
  assign bus.msg_adv  = round_en;

endmodule

// File: tb/tb_compress_ctrl.sv
// Directed bench for compress_ctrl: a cycle-indexed reference model checked
// every cycle, plus literal timing/count expectations per scenario.
module tb_compress_ctrl;

  localparam int ROUNDS = 64;
`ifdef CTRL_MSG_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  compress_ctrl_if ctrl_if ();

  compress_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ctrl_if)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n0 = 0;
  int soc_log[$];
  int eoc_log[$];
  int done_log[$];
  int ren_cnt = 0;
  int adv_cnt = 0;
  logic [31:0] k0_seen = '0;
  logic [31:0] k63_seen = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: a block accepted at the edge closing cycle a has soc in
  // a+1, rounds from a+2 until ROUNDS accepted rounds (last in L), eoc in L+1,
  // done in L+2; ready only outside that window.
  bit m_act = 1'b0;
  int m_soc_at = 0;
  int m_rounds = 0;
  int m_last_at = -1;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit e_ready, e_soc, e_eoc, e_ren, e_busy, e_done, in_rounds;
        int e_round;
        logic [44:0] act_v, exp_v;
        if (!rst_n) begin
          m_act = 1'b0;
          m_last_at = -1;
        end
        in_rounds = m_act && (cyc > m_soc_at) && (m_last_at < 0);
        e_ready   = !m_act;
        e_soc     = m_act && (cyc == m_soc_at);
        e_ren     = in_rounds && (STALL ? ctrl_if.msg_valid : 1'b1);
        e_round   = in_rounds ? m_rounds : 0;
        e_eoc     = m_act && (m_last_at >= 0) && (cyc == m_last_at + 1);
        e_done    = m_act && (m_last_at >= 0) && (cyc == m_last_at + 2);
        e_busy    = m_act && !e_done;
        exp_v = {e_ready, e_soc, e_eoc, e_ren, e_ren, 6'(e_round), K_REF[e_round], e_busy, e_done};
        act_v = {ctrl_if.ready, ctrl_if.soc, ctrl_if.eoc, ctrl_if.round_en, ctrl_if.msg_adv,
                 ctrl_if.round, ctrl_if.k, ctrl_if.busy, ctrl_if.done};
        check($sformatf("cycle %0d outputs {rdy,soc,eoc,ren,adv,rnd,k,busy,done}", cyc), 64'(act_v), 64'(exp_v));

        if (ctrl_if.soc) begin soc_log.push_back(cyc); k0_seen = ctrl_if.k; end
        if (ctrl_if.eoc) eoc_log.push_back(cyc);
        if (ctrl_if.done) done_log.push_back(cyc);
        if (ctrl_if.round_en) ren_cnt++;
        if (ctrl_if.msg_adv) adv_cnt++;
        if (ctrl_if.round == 6'd63) k63_seen = ctrl_if.k;

        if (rst_n) begin
          if (m_act && e_ren) begin
            m_rounds++;
            if (m_rounds == ROUNDS) m_last_at = cyc;
          end
          if ((!m_act || e_done) && ctrl_if.start) begin
            m_act = 1'b1;
            m_soc_at = cyc + 1;
            m_rounds = 0;
            m_last_at = -1;
          end else if (e_done) begin
            m_act = 1'b0;
          end
        end
        cyc++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    soc_log.delete();
    eoc_log.delete();
    done_log.delete();
    ren_cnt = 0;
    adv_cnt = 0;
    k0_seen = '0;
    k63_seen = '0;
  endtask

  task automatic pulse_start();
    ctrl_if.start = 1'b1;
    n0 = cyc;
    wait_cycles(1);
    ctrl_if.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int b = budget;
    while (done_log.size() < target && b > 0) begin
      wait_cycles(1);
      b--;
    end
    check(nm, 64'(done_log.size()), 64'(target));
  endtask

  initial begin
    ctrl_if.start = 1'b0;
    ctrl_if.msg_valid = 1'b0;
    wait_cycles(3);
    check("reset ready", 64'(ctrl_if.ready), 64'd1);
    check("reset k", 64'(ctrl_if.k), 64'h428a2f98);
    check("reset busy", 64'(ctrl_if.busy), 64'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Nominal block
    clear_logs();
    ctrl_if.msg_valid = 1'b1;
    pulse_start();
    wait_done(1, 200, "nominal done seen");
    wait_cycles(2);
    if (soc_log.size() > 0) check("nominal soc cycle", 64'(soc_log[0] - n0), 64'd1);
    else check("nominal soc seen", 64'd0, 64'd1);
    if (eoc_log.size() > 0) check("nominal eoc cycle", 64'(eoc_log[0] - n0), 64'd66);
    else check("nominal eoc seen", 64'd0, 64'd1);
    if (done_log.size() > 0) check("nominal done cycle", 64'(done_log[0] - n0), 64'd67);
    check("nominal msg_adv count", 64'(adv_cnt), 64'd64);
    check("nominal k round 0", 64'(k0_seen), 64'h428a2f98);
    check("nominal k round 63", 64'(k63_seen), 64'hc67178f2);

`ifdef CTRL_MSG_STALL_EN
    // Three-cycle stall at round 10
    clear_logs();
    ctrl_if.msg_valid = 1'b1;
    pulse_start();
    wait_cycles(11);
    ctrl_if.msg_valid = 1'b0;
    @(negedge clk);
    #1;
    check("stall round holds", 64'(ctrl_if.round), 64'd10);
    check("stall round_en low", 64'(ctrl_if.round_en), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    ctrl_if.msg_valid = 1'b1;
    wait_done(1, 200, "stall done seen");
    wait_cycles(2);
    if (done_log.size() > 0) check("stall done cycle", 64'(done_log[0] - n0), 64'd70);
    check("stall round_en count", 64'(ren_cnt), 64'd64);
`else
    // msg_valid ignored when stalls are compiled out
    clear_logs();
    ctrl_if.msg_valid = 1'b0;
    pulse_start();
    wait_done(1, 200, "no-stall done seen");
    wait_cycles(2);
    if (done_log.size() > 0) check("no-stall done cycle", 64'(done_log[0] - n0), 64'd67);
    check("no-stall round_en count", 64'(ren_cnt), 64'd64);
    ctrl_if.msg_valid = 1'b1;
`endif

    // Reset at round 30
    clear_logs();
    pulse_start();
    wait_cycles(31);
    check("pre-reset round", 64'(ctrl_if.round), 64'd30);
    rst_n = 1'b0;
    #1;
    check("mid reset ready", 64'(ctrl_if.ready), 64'd1);
    check("mid reset busy", 64'(ctrl_if.busy), 64'd0);
    check("mid reset round", 64'(ctrl_if.round), 64'd0);
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(80);
    check("aborted block eoc count", 64'(eoc_log.size()), 64'd0);
    check("aborted block done count", 64'(done_log.size()), 64'd0);
    clear_logs();
    pulse_start();
    wait_done(1, 200, "post-reset done seen");
    if (done_log.size() > 0) check("post-reset done cycle", 64'(done_log[0] - n0), 64'd67);
    wait_cycles(2);

    // start pulsed during ROUND is ignored
    clear_logs();
    pulse_start();
    wait_cycles(20);
    ctrl_if.start = 1'b1;
    @(negedge clk);
    #1;
    check("ready low during round", 64'(ctrl_if.ready), 64'd0);
    wait_cycles(1);
    ctrl_if.start = 1'b0;
    wait_done(1, 200, "ignored-start done seen");
    wait_cycles(80);
    check("ignored-start done count", 64'(done_log.size()), 64'd1);
    check("ignored-start soc count", 64'(soc_log.size()), 64'd1);

    // start held high across two blocks
    clear_logs();
    ctrl_if.start = 1'b1;
    n0 = cyc;
    wait_cycles(75);
    ctrl_if.start = 1'b0;
    wait_done(2, 200, "held-start done count");
    wait_cycles(2);
    if (soc_log.size() > 1) check("held-start second soc cycle", 64'(soc_log[1] - n0), 64'd68);
    else check("held-start second soc seen", 64'(soc_log.size()), 64'd2);
    if (done_log.size() > 1) check("held-start second done cycle", 64'(done_log[1] - n0), 64'd134);
    wait_cycles(5);
    check("idle after held-start", 64'(ctrl_if.ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
